// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: turns a frame start request into a train of
// per-sample valid strobes grouped into chirps, with an optional idle gap
// between chirps. Configuration is latched at frame start; every output is
// registered and follows the causing sample_tick by one cycle.
module adc_capture_ctrl #(
  parameter int SAMP_WIDTH  = 10,
  parameter int CHIRP_WIDTH = 8,
  parameter int GAP_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SAMP_WIDTH-1:0]  cfg_samples,
  input  logic [CHIRP_WIDTH-1:0] cfg_chirps,
  input  logic [GAP_WIDTH-1:0]   cfg_gap,
  input  logic                   sample_tick,
  output logic                   adc_valid_en,
  output logic [SAMP_WIDTH-1:0]  sample_idx,
  output logic [CHIRP_WIDTH-1:0] chirp_idx,
  output logic                   chirp_start,
  output logic                   chirp_end,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   cfg_err
);

  typedef enum logic [1:0] {IDLE, ACQ, GAP} state_e;

  state_e                 state_q, state_d;
  logic [SAMP_WIDTH-1:0]  samp_q, samp_d;
  logic [CHIRP_WIDTH-1:0] chirp_q, chirp_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [SAMP_WIDTH-1:0]  lat_samples_q, lat_samples_d;
  logic [CHIRP_WIDTH-1:0] lat_chirps_q, lat_chirps_d;
  logic [GAP_WIDTH-1:0]   lat_gap_q, lat_gap_d;
  logic                   valid_q, valid_d;
  logic [SAMP_WIDTH-1:0]  sidx_q, sidx_d;
  logic [CHIRP_WIDTH-1:0] cidx_q, cidx_d;
  logic                   cs_q, cs_d;
  logic                   ce_q, ce_d;
  logic                   fd_q, fd_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic last_samp, last_chirp, gap_done;

  assign last_samp  = (samp_q == lat_samples_q - SAMP_WIDTH'(1));
  assign last_chirp = (chirp_q == lat_chirps_q - CHIRP_WIDTH'(1));
  assign gap_done   = (gap_q == lat_gap_q - GAP_WIDTH'(1));

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d       = state_q;
    samp_d        = samp_q;
    chirp_d       = chirp_q;
    gap_d         = gap_q;
    lat_samples_d = lat_samples_q;
    lat_chirps_d  = lat_chirps_q;
    lat_gap_d     = lat_gap_q;
    valid_d       = 1'b0;
    sidx_d        = sidx_q;
    cidx_d        = cidx_q;
    cs_d          = 1'b0;
    ce_d          = 1'b0;
    fd_d          = 1'b0;
    err_d         = 1'b0;
    // busy trails the state by one cycle, so it is still high alongside
    // frame_done and drops on the following cycle
    busy_d        = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (start && !abort && !busy_q) begin
          if (cfg_samples != '0 && cfg_chirps != '0) begin
            lat_samples_d = cfg_samples;
            lat_chirps_d  = cfg_chirps;
            lat_gap_d     = cfg_gap;
            samp_d        = '0;
            chirp_d       = '0;
            gap_d         = '0;
            sidx_d        = '0;
            cidx_d        = '0;
            state_d       = ACQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACQ: begin
        if (abort) begin
          samp_d  = '0;
          chirp_d = '0;
          gap_d   = '0;
          sidx_d  = '0;
          cidx_d  = '0;
          state_d = IDLE;
        end else if (sample_tick) begin
          valid_d = 1'b1;
          sidx_d  = samp_q;
          cidx_d  = chirp_q;
          cs_d    = (samp_q == '0);
          ce_d    = last_samp;
          if (last_samp) begin
            samp_d = '0;
            gap_d  = '0;
            if (last_chirp) begin
              fd_d    = 1'b1;
              chirp_d = '0;
              state_d = IDLE;
            end else begin
              chirp_d = chirp_q + CHIRP_WIDTH'(1);
              state_d = (lat_gap_q != '0) ? GAP : ACQ;
            end
          end else begin
            samp_d = samp_q + SAMP_WIDTH'(1);
          end
        end
      end
      GAP: begin
        if (abort) begin
          samp_d  = '0;
          chirp_d = '0;
          gap_d   = '0;
          sidx_d  = '0;
          cidx_d  = '0;
          state_d = IDLE;
        end else if (gap_done) begin
          gap_d   = '0;
          state_d = ACQ;
        end else begin
          gap_d = gap_q + GAP_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, latched configuration and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      samp_q        <= '0;
      chirp_q       <= '0;
      gap_q         <= '0;
      lat_samples_q <= '0;
      lat_chirps_q  <= '0;
      lat_gap_q     <= '0;
      valid_q       <= 1'b0;
      sidx_q        <= '0;
      cidx_q        <= '0;
      cs_q          <= 1'b0;
      ce_q          <= 1'b0;
      fd_q          <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      samp_q        <= samp_d;
      chirp_q       <= chirp_d;
      gap_q         <= gap_d;
      lat_samples_q <= lat_samples_d;
      lat_chirps_q  <= lat_chirps_d;
      lat_gap_q     <= lat_gap_d;
      valid_q       <= valid_d;
      sidx_q        <= sidx_d;
      cidx_q        <= cidx_d;
      cs_q          <= cs_d;
      ce_q          <= ce_d;
      fd_q          <= fd_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign adc_valid_en = valid_q;
  assign sample_idx   = sidx_q;
  assign chirp_idx    = cidx_q;
  assign chirp_start  = cs_q;
  assign chirp_end    = ce_q;
  assign frame_done   = fd_q;
  assign busy         = busy_q;
  assign cfg_err      = err_q;

endmodule
